// File: rtl/jt12_kon_wr.sv
// Queues CPU key-on writes (register 0x28) and presents them one at a time to jt12_kon.
// Optional build macro: JT12_KON_COALESCE_EN merges a write into the newest queued entry for the same channel.
module jt12_kon_wr #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       cfg_wr,
  input  logic [7:0] cfg_addr,
  input  logic [7:0] cfg_din,
  input  logic       ovf_clr,
  input  logic [1:0] next_op,
  input  logic [2:0] next_ch,
  output logic       up_keyon,
  output logic [3:0] keyon_op,
  output logic [2:0] keyon_ch,
  output logic       busy,
  output logic       ovf,
  output logic       bad_ch
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t        state;
  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          accept;
  logic          ch_bad;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push;
  logic          coalesce;
  logic          drop_full;
  logic          apply_hit;
  logic [AW-1:0] newest_ptr;
  logic          unused_din3;

  assign unused_din3 = cfg_din[3];

  assign accept     = clk_en && cfg_wr && (cfg_addr == 8'h28);
  assign ch_bad     = (cfg_din[1:0] == 2'b11);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(DEPTH));
  assign pop        = clk_en && (state == ST_IDLE) && !fifo_empty;
  assign newest_ptr = wr_ptr - 1'b1;

`ifdef JT12_KON_COALESCE_EN
  // The newest entry is only mergeable if it is not the one leaving this cycle.
  logic newest_live;
  assign newest_live = pop ? (count > (AW+1)'(1)) : !fifo_empty;
  assign coalesce    = accept && !ch_bad && newest_live &&
                       (mem[newest_ptr][2:0] == cfg_din[2:0]);
`else
  assign coalesce    = 1'b0;
`endif

  assign push      = accept && !ch_bad && !coalesce && (!fifo_full || pop);
  assign drop_full = accept && !ch_bad && !coalesce && fifo_full && !pop;

  // The strobe cycle itself is excluded: up_keyon is high only in the first WAIT cycle.
  assign apply_hit = (state == ST_WAIT) && !up_keyon &&
                     (next_ch == keyon_ch) && (next_op == 2'd3);

  assign busy = !fifo_empty || (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)          mem[wr_ptr] <= {cfg_din[7:4], cfg_din[2:0]};
    else if (coalesce) mem[newest_ptr][6:3] <= cfg_din[7:4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      up_keyon <= 1'b0;
      keyon_op <= 4'd0;
      keyon_ch <= 3'd0;
    end else if (clk_en) begin
      up_keyon <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            up_keyon             <= 1'b1;
            {keyon_op, keyon_ch} <= mem[rd_ptr];
            state                <= ST_WAIT;
          end
        end
        ST_WAIT: if (apply_hit) state <= ST_GAP;
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A set condition in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf    <= 1'b0;
      bad_ch <= 1'b0;
    end else if (clk_en) begin
      if (drop_full)            ovf <= 1'b1;
      else if (ovf_clr)         ovf <= 1'b0;
      if (accept && ch_bad)     bad_ch <= 1'b1;
      else if (ovf_clr)         bad_ch <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jt12_kon_wr.sv
// Directed bench for jt12_kon_wr; drives a modelled 24-slot counter and checks strobe timing.
module tb_jt12_kon_wr;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic       cfg_wr;
  logic [7:0] cfg_addr;
  logic [7:0] cfg_din;
  logic       ovf_clr;
  logic [1:0] next_op;
  logic [2:0] next_ch;
  logic       up_keyon;
  logic [3:0] keyon_op;
  logic [2:0] keyon_ch;
  logic       busy;
  logic       ovf;
  logic       bad_ch;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;
  int slot_idx = 0;

  jt12_kon_wr #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .cfg_wr   (cfg_wr),
    .cfg_addr (cfg_addr),
    .cfg_din  (cfg_din),
    .ovf_clr  (ovf_clr),
    .next_op  (next_op),
    .next_ch  (next_ch),
    .up_keyon (up_keyon),
    .keyon_op (keyon_op),
    .keyon_ch (keyon_ch),
    .busy     (busy),
    .ovf      (ovf),
    .bad_ch   (bad_ch)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic drive_slot();
    int pos;
    pos     = slot_idx % 6;
    next_ch = (pos < 3) ? 3'(pos) : 3'(pos + 1);
    next_op = 2'(slot_idx / 6);
  endtask

  task automatic set_slot(input int idx);
    slot_idx = idx % 24;
    drive_slot();
  endtask

  task automatic cyc();
    logic en;
    en = clk_en;
    @(posedge clk);
    #1;
    edge_n++;
    if (en) begin
      slot_idx = (slot_idx + 1) % 24;
      drive_slot();
    end
  endtask

  task automatic write(input logic [7:0] din);
    cfg_wr   = 1'b1;
    cfg_addr = 8'h28;
    cfg_din  = din;
    cyc();
    cfg_wr   = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (edge_n < target) cyc();
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expects the next strobe exactly at edge 'target', quiet and stable before it, one cycle long.
  task automatic expect_strobe(input int target, input logic [3:0] op, input logic [2:0] ch,
                               input string tag);
    logic       early;
    logic [3:0] op0;
    logic [2:0] ch0;
    early = 1'b0;
    op0   = keyon_op;
    ch0   = keyon_ch;
    while (edge_n < target) begin
      cyc();
      if (edge_n < target && (up_keyon || keyon_op != op0 || keyon_ch != ch0)) early = 1'b1;
    end
    chk({tag, "_quiet"}, early, 0);
    chk({tag, "_up"}, up_keyon, 1);
    chk({tag, "_op"}, keyon_op, op);
    chk({tag, "_ch"}, keyon_ch, ch);
    cyc();
    chk({tag, "_one"}, up_keyon, 0);
    chk({tag, "_hold"}, {keyon_op, keyon_ch}, {op, ch});
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; cfg_wr = 1'b0; cfg_addr = 8'h00; cfg_din = 8'h00;
    ovf_clr = 1'b0;
    set_slot(0);
    repeat (3) cyc();
    chk("rst_up", up_keyon, 0);
    chk("rst_op", keyon_op, 0);
    chk("rst_ch", keyon_ch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_bad", bad_ch, 0);
    rst = 1'b0;
    cyc();

    // 1: single write, strobe next cycle, drain after ch1/op3 (edge 19) + GAP
    set_slot(0); edge_n = -1;
    write(8'hF1);
    chk("t1_nostrobe_yet", up_keyon, 0);
    chk("t1_busy", busy, 1);
    expect_strobe(1, 4'hF, 3'd1, "t1");
    run_to(19);
    chk("t1_busy_gap", busy, 1);
    cyc();
    chk("t1_idle", busy, 0);

    // 2: write lands on its own apply slot -> waits a full 24 slots
    set_slot(20); edge_n = -1;
    write(8'h52);
    expect_strobe(1, 4'h5, 3'd2, "t2");
    run_to(24);
    chk("t2_busy_gap", busy, 1);
    cyc();
    chk("t2_idle", busy, 0);

    // 3: six back-to-back writes, fifth queued fills FIFO, sixth dropped
    set_slot(0); edge_n = -1;
    write(8'h10);
    write(8'h21);
    chk("t3_s0_up", up_keyon, 1);
    chk("t3_s0_op", keyon_op, 4'h1);
    chk("t3_s0_ch", keyon_ch, 3'd0);
    write(8'h32);
    write(8'h44);
    write(8'h55);
    chk("t3_no_ovf_yet", ovf, 0);
    write(8'h66);
    chk("t3_ovf", ovf, 1);
    expect_strobe(20, 4'h2, 3'd1, "t3_s1");
    expect_strobe(45, 4'h3, 3'd2, "t3_s2");
    expect_strobe(70, 4'h4, 3'd4, "t3_s3");
    expect_strobe(95, 4'h5, 3'd5, "t3_s4");
    run_to(118);
    chk("t3_busy_gap", busy, 1);
    cyc();
    chk("t3_idle", busy, 0);
    chk("t3_no_sixth", up_keyon, 0);

    // 4: channel codes 3 and 7 are rejected
    write(8'h13);
    chk("t4_bad", bad_ch, 1);
    write(8'h17);
    cyc(); cyc();
    chk("t4_nostrobe", up_keyon, 0);
    chk("t4_notbusy", busy, 0);
    ovf_clr = 1'b1;
    write(8'h37);
    ovf_clr = 1'b0;
    chk("t4_set_wins", bad_ch, 1);
    chk("t4_ovf_clr", ovf, 0);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("t4_bad_clr", bad_ch, 0);

    // 5: two writes to ch0 during WAIT
    set_slot(0); edge_n = -1;
    write(8'h21);
    write(8'h10);
    chk("t5_s0_up", up_keyon, 1);
    chk("t5_s0_ch", keyon_ch, 3'd1);
    write(8'hF0);
`ifdef JT12_KON_COALESCE_EN
    expect_strobe(21, 4'hF, 3'd0, "t5_merged");
    run_to(42);
    chk("t5_busy_gap", busy, 1);
    cyc();
    chk("t5_idle", busy, 0);
`else
    expect_strobe(21, 4'h1, 3'd0, "t5_first");
    expect_strobe(44, 4'hF, 3'd0, "t5_second");
    run_to(66);
    chk("t5_busy_gap", busy, 1);
    cyc();
    chk("t5_idle", busy, 0);
`endif
    chk("t5_ovf", ovf, 0);

    // 7: clk_en low ignores writes and stretches the strobe
    clk_en = 1'b0;
    write(8'hF1);
    cyc(); cyc();
    chk("t7_ignored_busy", busy, 0);
    chk("t7_ignored_up", up_keyon, 0);
    clk_en = 1'b1;
    set_slot(0); edge_n = -1;
    write(8'h61);
    cyc();
    chk("t7_up", up_keyon, 1);
    clk_en = 1'b0;
    repeat (3) cyc();
    chk("t7_up_held", up_keyon, 1);
    clk_en = 1'b1;
    cyc();
    chk("t7_up_drop", up_keyon, 0);
    chk("t7_op_hold", keyon_op, 4'h6);

    // 6: reset during WAIT with an entry pending
    write(8'h13);
    set_slot(0); edge_n = -1;
    write(8'h42);
    cyc();
    write(8'h54);
    cyc();
    chk("t6_pre_busy", busy, 1);
    rst = 1'b1;
    cyc();
    chk("t6_rst_up", up_keyon, 0);
    chk("t6_rst_op", keyon_op, 0);
    chk("t6_rst_ch", keyon_ch, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ovf", ovf, 0);
    chk("t6_rst_bad", bad_ch, 0);
    rst = 1'b0;
    cyc(); cyc();
    chk("t6_abandon_up", up_keyon, 0);
    chk("t6_abandon_busy", busy, 0);
    set_slot(0); edge_n = -1;
    write(8'hA4);
    expect_strobe(1, 4'hA, 3'd4, "t6_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
